iclarke_seq: RTL and testbench

- Multi-cycle sequencer for the inverse Clarke transform in the FOC output path. Converts stationary-frame (alpha, beta) to three-phase (a, b, c) ahead of the PWM stage.
- Uses one shared signed multiplier for the sqrt(3)/2 term, driven by a small FSM.
- Valid/ready handshake on input and output, so upstream and downstream stages can stall it.

---
 rtl/iclarke_seq_if.sv | 28 ++
 rtl/iclarke_seq.sv | 114 +++++++++++
 tb/tb_iclarke_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/iclarke_seq_if.sv
// iclarke_seq_if: valid/ready stream bundle for the inverse Clarke sequencer.
//   in_valid/in_ready/alpha/beta   : sample request (upstream -> block)
//   out_valid/out_ready/a/b/c/sat  : phase result (block -> downstream)
// master = the side that feeds samples and consumes results; slave = the block.
interface iclarke_seq_if #(
    parameter int D_WIDTH = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [D_WIDTH-1:0] a;
    logic signed [D_WIDTH-1:0] b;
    logic signed [D_WIDTH-1:0] c;
    logic                      sat;

    modport master (
        output in_valid, alpha, beta, out_ready,
        input  in_ready, out_valid, a, b, c, sat
    );

    modport slave (
        input  in_valid, alpha, beta, out_ready,
        output in_ready, out_valid, a, b, c, sat
    );
endinterface

// File: rtl/iclarke_seq.sv
// iclarke_seq: multi-cycle inverse Clarke transform (alpha, beta) -> (a, b, c).
//   a = alpha, b = sat(-alpha/2 + k*beta), c = sat(-alpha/2 - k*beta), k = sqrt(3)/2.
//   One shared signed multiply (MUL state), sums and clamp (SUM state), result
//   held until downstream takes it (HOLD state).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : iclarke_seq_if.slave (in_valid/in_ready/alpha/beta,
//          out_valid/out_ready/a/b/c/sat)
module iclarke_seq #(
    parameter int          D_WIDTH   = 32,
    parameter int          Q_BITS    = 10,
    parameter int unsigned K_SQRT3_2 = 887
) (
    input  logic          clk,
    input  logic          rst,
    iclarke_seq_if.slave  bus
);
    localparam int PW = 2 * D_WIDTH;
    localparam int SW = D_WIDTH + 2;

    // Constant held in a full-width signed container so the product is signed.
    localparam logic signed [PW-1:0]      KW   = PW'(K_SQRT3_2);
    localparam logic signed [SW-1:0]      SMAX = {3'b000, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]      SMIN = {3'b111, {(D_WIDTH-1){1'b0}}};
    localparam logic signed [D_WIDTH-1:0] DMAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [D_WIDTH-1:0] DMIN = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, SUM, HOLD} state_t;

    state_t state, state_nx;

    logic signed [D_WIDTH-1:0] alpha_r, beta_r;
    logic signed [D_WIDTH:0]   m_r;
    logic signed [D_WIDTH-1:0] a_r, b_r, c_r;
    logic                      sat_r;

    // Datapath signals
    logic signed [PW-1:0]      prod;
    logic signed [D_WIDTH:0]   m_nx;
    logic signed [D_WIDTH-1:0] h;
    logic signed [SW-1:0]      hx, mx, sb, sc;
    logic signed [D_WIDTH-1:0] b_nx, c_nx;
    logic                      b_clip, c_clip;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = MUL;
            MUL:     state_nx = SUM;
            SUM:     state_nx = HOLD;
            HOLD:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);

    // ---------------- datapath ----------------
    always_comb begin
        // Single multiplier instance; >>> floors, then keep D_WIDTH+1 bits
        // so k*beta for full-scale beta still fits.
        prod = $signed({{D_WIDTH{beta_r[D_WIDTH-1]}}, beta_r}) * KW;
        m_nx = (D_WIDTH+1)'(prod >>> Q_BITS);

        h  = alpha_r >>> 1;
        hx = $signed({{2{h[D_WIDTH-1]}}, h});
        mx = $signed({m_r[D_WIDTH], m_r});
        sb = mx - hx;
        sc = -hx - mx;

        b_clip = (sb > SMAX) || (sb < SMIN);
        c_clip = (sc > SMAX) || (sc < SMIN);
        b_nx   = (sb > SMAX) ? DMAX : (sb < SMIN) ? DMIN : D_WIDTH'(sb);
        c_nx   = (sc > SMAX) ? DMAX : (sc < SMIN) ? DMIN : D_WIDTH'(sc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alpha_r <= '0;
            beta_r  <= '0;
            m_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            sat_r   <= 1'b0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                alpha_r <= bus.alpha;
                beta_r  <= bus.beta;
            end
            if (state == MUL) m_r <= m_nx;
            // Outputs only move on SUM->HOLD; they persist after the handshake.
            if (state == SUM) begin
                a_r   <= alpha_r;
                b_r   <= b_nx;
                c_r   <= c_nx;
                sat_r <= b_clip | c_clip;
            end
        end
    end

    assign bus.a   = a_r;
    assign bus.b   = b_r;
    assign bus.c   = c_r;
    assign bus.sat = sat_r;
endmodule

// File: tb/tb_iclarke_seq.sv
module tb_iclarke_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    iclarke_seq_if #(.D_WIDTH(32)) bus ();

    iclarke_seq #(.D_WIDTH(32), .Q_BITS(10), .K_SQRT3_2(887)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive one sample; returns number of edges after the accept edge until
    // out_valid is seen (-1 on timeout). Leaves DUT in HOLD.
    task automatic send(input logic signed [31:0] al, input logic signed [31:0] be,
                        output int lat);
        int w = 0;
        while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
        bus.alpha = al; bus.beta = be; bus.in_valid = 1'b1;
        @(posedge clk); #1;           // accept edge
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.alpha = '0; bus.beta = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.a !== 0 || bus.b !== 0 || bus.c !== 0 || bus.sat !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got a=%0d b=%0d c=%0d sat=%0b want 0", bus.a, bus.b, bus.c, bus.sat); end
    endtask

    task automatic test_nominal();
        int lat;
        bus.out_ready = 1'b1;
        send(40, 32, lat);
        // accept edge + 2 more edges = out_valid visible after the third edge
        checks++; if (lat !== 2) begin errors++; $display("FAIL nom_latency got %0d want 2", lat); end
        checks++; if (bus.a !== 40 || bus.b !== 7 || bus.c !== -47 || bus.sat !== 1'b0) begin
            errors++; $display("FAIL nom1_abc got %0d/%0d/%0d sat=%0b want 40/7/-47 sat=0", bus.a, bus.b, bus.c, bus.sat); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL nom_handshake got ov=%0b ir=%0b want 0/1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.a !== 40 || bus.b !== 7 || bus.c !== -47) begin
            errors++; $display("FAIL nom_persist got %0d/%0d/%0d want 40/7/-47", bus.a, bus.b, bus.c); end
        send(32, 40, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL nom2_latency got %0d want 2", lat); end
        checks++; if (bus.a !== 32 || bus.b !== 18 || bus.c !== -50 || bus.sat !== 1'b0) begin
            errors++; $display("FAIL nom2_abc got %0d/%0d/%0d sat=%0b want 32/18/-50 sat=0", bus.a, bus.b, bus.c, bus.sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int lat;
        bus.out_ready = 1'b0;
        send(40, 32, lat);            // now in HOLD with non-zero outputs
        #2 rst = 1'b1;                // mid-cycle, no clock edge until release check
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL async_rst_hs got ov=%0b ir=%0b want 0/1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.a !== 0 || bus.b !== 0 || bus.c !== 0 || bus.sat !== 1'b0) begin
            errors++; $display("FAIL async_rst_out got %0d/%0d/%0d sat=%0b want 0", bus.a, bus.b, bus.c, bus.sat); end
        @(posedge clk); #3 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_negative();
        int lat;
        bus.out_ready = 1'b1;
        // m = floor(-35480/1024) = -35, h = -16
        send(-32, -40, lat);
        checks++; if (bus.a !== -32 || bus.b !== -19 || bus.c !== 51 || bus.sat !== 1'b0) begin
            errors++; $display("FAIL neg_floor got %0d/%0d/%0d sat=%0b want -32/-19/51 sat=0", bus.a, bus.b, bus.c, bus.sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad = 0;
        int w = 0;
        bus.out_ready = 1'b0;
        send(40, 32, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", lat); end
        bus.alpha = 32; bus.beta = 40; bus.in_valid = 1'b1;   // pending sample
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.a !== 40 || bus.b !== 7 || bus.c !== -47) bad++;
        end
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL bp_hold got %0d bad cycles ov=%0b ir=%0b abc=%0d/%0d/%0d want 0", bad, bus.out_valid, bus.in_ready, bus.a, bus.b, bus.c); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got ov=%0b ir=%0b want 0/1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;           // pending sample accepted here
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got ir=%0b want 0", bus.in_ready); end
        while (!bus.out_valid && w < 20) begin @(posedge clk); #1; w++; end
        checks++; if (bus.a !== 32 || bus.b !== 18 || bus.c !== -50 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_pending got %0d/%0d/%0d ov=%0b want 32/18/-50 ov=1", bus.a, bus.b, bus.c, bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int lat;
        bus.out_ready = 1'b1;
        // m = floor((2^31-1)*887/2^10) = 1860173823, -h = 2^30
        // b = 2^30 + m -> clamps; c = 2^30 - m = -786431999
        send(32'sh8000_0000, 32'sh7fff_ffff, lat);
        checks++; if (bus.a !== 32'sh8000_0000 || bus.b !== 32'sh7fff_ffff) begin
            errors++; $display("FAIL sat_ab got %0d/%0d want -2147483648/2147483647", bus.a, bus.b); end
        checks++; if (bus.c !== -786431999 || bus.sat !== 1'b1) begin
            errors++; $display("FAIL sat_c got %0d sat=%0b want -786431999 sat=1", bus.c, bus.sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_sum();
        int lat;
        int seen = 0;
        bus.out_ready = 1'b1;
        bus.alpha = 40; bus.beta = 32; bus.in_valid = 1'b1;
        @(posedge clk); #1;           // accept -> MUL
        bus.in_valid = 1'b0;
        @(posedge clk); #1;           // SUM
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_sum_drop got %0d valid cycles want 0", seen); end
        send(32, 40, lat);
        checks++; if (bus.a !== 32 || bus.b !== 18 || bus.c !== -50 || lat !== 2) begin
            errors++; $display("FAIL rst_sum_fresh got %0d/%0d/%0d lat=%0d want 32/18/-50 lat=2", bus.a, bus.b, bus.c, lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_async_reset();
        test_negative();
        test_back_to_back();
        test_saturation();
        test_reset_in_sum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
